// File: rtl/or16_result_skid.sv
// Two-entry skid buffer between the combinational Or16 stage and a valid/ready consumer.
// Handshake flags decode from registered state only, so out_ready never reaches in_ready.
module or16_result_skid #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nonzero,
    output logic [15:0]      xfer_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [15:0]      count_q, count_d;
    logic             accept;
    logic             pop;

    assign out_valid   = (state_q != StEmpty);
    assign in_ready    = (state_q != StFull);
    assign out_data    = main_q;
    assign out_nonzero = out_valid & (|main_q);
    assign xfer_count  = count_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = pop ? count_q + 16'd1 : count_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    main_d  = in_data;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = StFull;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only a pop can move the state
                if (pop) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_or16_result_skid.sv
// Self-checking bench for or16_result_skid: scoreboard of accepted words, popped in order.
module tb_or16_result_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_nonzero;
    logic [15:0] xfer_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_word;
    int          exp_pops = 0;

    or16_result_skid #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nonzero(out_nonzero),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL pop_unexpected: got out_data=%h, required no output", out_data);
                end else begin
                    exp_word = sb.pop_front();
                    if (out_data !== exp_word) begin
                        n_fails++;
                        $display("FAIL pop_data: got %h, required %h", out_data, exp_word);
                    end
                    n_checks++;
                    if (out_nonzero !== (exp_word != 16'h0000)) begin
                        n_fails++;
                        $display("FAIL pop_nonzero: got %b, required %b", out_nonzero,
                                 exp_word != 16'h0000);
                    end
                end
                exp_pops++;
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        exp_pops = 0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000 ||
            out_nonzero !== 1'b0 || xfer_count !== 16'h0000) begin
            n_fails++;
            $display("FAIL reset_state: got v=%b r=%b d=%h nz=%b cnt=%h, required 0 1 0000 0 0000",
                     out_valid, in_ready, out_data, out_nonzero, xfer_count);
        end
        // out_ready toggling in EMPTY must not count
        for (int i = 0; i < 4; i++) begin
            out_ready = i[0];
            cycle();
        end
        n_checks++;
        if (xfer_count !== 16'h0000) begin
            n_fails++;
            $display("FAIL empty_toggle_count: got %h, required 0000", xfer_count);
        end
    endtask

    task automatic test_basic();
        logic [15:0] words[3];
        logic        nz[3];
        words = '{16'h00F0, 16'h0F00, 16'h0000};
        nz    = '{1'b1, 1'b1, 1'b0};
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== words[i] || out_nonzero !== nz[i]) begin
                n_fails++;
                $display("FAIL basic_word%0d: got v=%b d=%h nz=%b, required 1 %h %b", i,
                         out_valid, out_data, out_nonzero, words[i], nz[i]);
            end
        end
        in_valid = 1'b0;
        cycle();
        n_checks++;
        if (xfer_count !== 16'd3 || out_valid !== 1'b0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL basic_done: got cnt=%h v=%b pending=%0d, required 0003 0 0",
                     xfer_count, out_valid, sb.size());
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_ready_after1: got %b, required 1", in_ready);
        end
        in_data = 16'h0002;
        cycle();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_ready_after2: got %b, required 0", in_ready);
        end
        in_data = 16'h0003;
        cycle();
        cycle();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 16'h0001 || sb.size() != 2) begin
            n_fails++;
            $display("FAIL bp_stall: got r=%b d=%h stored=%0d, required 0 0001 2",
                     in_ready, out_data, sb.size());
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1 || out_data !== 16'h0002) begin
            n_fails++;
            $display("FAIL bp_release: got r=%b d=%h, required 1 0002", in_ready, out_data);
        end
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && out_valid; i++) cycle();
        n_checks++;
        if (xfer_count !== 16'd3 || out_valid !== 1'b0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL bp_done: got cnt=%h v=%b pending=%0d, required 0003 0 0",
                     xfer_count, out_valid, sb.size());
        end
    endtask

    task automatic test_stream();
        int   i = 0;
        int   budget = 0;
        logic took;
        apply_reset();
        while (i < 256 && budget < 5000) begin
            in_valid  = 1'b1;
            in_data   = i[15:0] | 16'h00FF;
            out_ready = 1'($urandom_range(0, 1));
            took      = in_ready;
            cycle();
            if (took) i++;
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && out_valid; k++) cycle();
        n_checks++;
        if (i != 256 || xfer_count !== 16'd256 || sb.size() != 0 || exp_pops != 256) begin
            n_fails++;
            $display("FAIL stream_done: got sent=%0d cnt=%0d pending=%0d, required 256 256 0",
                     i, xfer_count, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0100 + i);
            cycle();
            if (in_ready !== 1'b1 || out_valid !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0 || xfer_count !== 16'd19) begin
            n_fails++;
            $display("FAIL b2b: got stalls=%0d cnt=%0d, required 0 19", bad, xfer_count);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = i[15:0];
            cycle();
        end
        n_checks++;
        if (xfer_count !== 16'hFFFF) begin
            n_fails++;
            $display("FAIL wrap_ffff: got %h, required ffff", xfer_count);
        end
        in_valid = 1'b0;
        cycle();
        n_checks++;
        if (xfer_count !== 16'h0000 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL wrap_zero: got cnt=%h v=%b, required 0000 0", xfer_count, out_valid);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hA5A5;
        cycle();
        cycle();
        out_ready = 1'b0;
        in_data   = 16'h5A5A;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || xfer_count !== 16'd1) begin
            n_fails++;
            $display("FAIL arst_setup: got r=%b cnt=%h, required 0 0001", in_ready, xfer_count);
        end
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000 ||
            out_nonzero !== 1'b0 || xfer_count !== 16'h0000) begin
            n_fails++;
            $display("FAIL arst_midcycle: got v=%b r=%b d=%h nz=%b cnt=%h, required 0 1 0000 0 0000",
                     out_valid, in_ready, out_data, out_nonzero, xfer_count);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/or16_result_skid.md
# or16_result_skid

- Registered two-entry skid buffer that captures 16-bit results from the combinational Or16 gate stage and hands them to the next consumer over a valid/ready handshake.
- Decouples the combinational datapath from downstream back-pressure without dropping or duplicating words.
- Sustains one transfer per cycle.
- Adds a registered-data nonzero flag and a transfer counter for CPU status and debug.

## Interface
Parameters:
- WIDTH, 16, data width. Only 16 is supported and verified.

Ports:
- Clock and reset are fixed for this block: one clock, `clk`; reset `rst` is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word on in_data is valid.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  16  result word from the Or16 stage.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  16  registered head word.
- out_nonzero  output  1  OR-reduction of out_data; forced 0 when out_valid=0.
- xfer_count  output  16  number of completed output handshakes, wrapping.

## Operation
Handshake definitions:
- Accept = in_valid & in_ready.
- Pop = out_valid & out_ready.

Storage:
- Main register (head), drives out_data.
- Skid register holds one overflow word.

State encoding: EMPTY (0 words), ONE (main valid), FULL (main+skid valid).
- out_valid = (state != EMPTY).
- in_ready = (state != FULL).
- Both are decoded from registered state only; no combinational path from out_ready to in_ready.

Transitions:
- EMPTY: accept -> ONE, main<=in_data. No accept -> EMPTY.
- ONE, accept & pop -> ONE, main<=in_data.
- ONE, accept & !pop -> FULL, skid<=in_data, main unchanged.
- ONE, pop & !accept -> EMPTY.
- ONE, neither -> ONE.
- FULL: in_ready=0, so in_valid is ignored and in_data is not captured.
- FULL, pop -> ONE, main<=skid.
- FULL, no pop -> FULL, both registers held.

Data rules:
- Words leave in strict arrival order.
- out_data is stable while out_valid=1 and out_ready=0.
- out_data is don't-care in EMPTY but must not change on a stall.
- out_nonzero = out_valid & (|out_data).
- xfer_count increments by 1 on each pop and wraps 0xFFFF -> 0x0000.
- No other arithmetic is performed; data passes through unmodified.

## Timing
Reset values (rst asserted, asynchronously):
- state=EMPTY, out_valid=0, in_ready=1.
- out_data=0x0000, skid=0x0000, out_nonzero=0, xfer_count=0x0000.

Reset behaviour:
- Reset mid-operation discards both stored words immediately, with no pop counted.
- First accept is permitted on the first rising edge after rst deasserts.

Latency and throughput:
- A word accepted at edge N is on out_data with out_valid=1 from edge N until its pop edge; this is one-cycle latency.
- Continuous in_valid=1 and out_ready=1 gives one word per cycle and the state stays in ONE.

Boundary cases:
- Back-pressure: the first stalled cycle absorbs one extra word into skid. in_ready drops the cycle after.
- Simultaneous accept and pop in ONE: replace main, with no bubble.
- Simultaneous events in FULL: only pop is possible; in_ready rises the cycle after the pop.
- out_ready toggling while EMPTY has no effect on the counter.

## Test plan
- Reset release, then inputs 0x00F0, 0x0F00, 0x0000 with out_ready=1 -> out_data 0x00F0, 0x0F00, 0x0000 on consecutive cycles; out_nonzero 1,1,0; xfer_count=3.
- Hold out_ready=0 and drive 0x0001, 0x0002, 0x0003 -> in_ready falls after the second accept; 0x0003 is held off; releasing out_ready yields 0x0001, 0x0002, 0x0003 in order, with no loss or duplicate.
- Stream 256 Or16 results (a=i, b=0x00FF) with random out_ready -> output sequence equals i|0x00FF in order; xfer_count=256.
- Preload xfer_count to 0xFFFF pops (65535), then one more pop -> xfer_count=0x0000.
- Assert rst asynchronously mid-cycle while FULL -> out_valid=0, in_ready=1, out_data=0, xfer_count=0 without waiting for a clock edge.
- Hold in_valid=1 with out_ready=1 from EMPTY -> one word per cycle, state never reaches FULL, in_ready stays 1.
